// File: rtl/codec_seq_pkg.sv
// Shared encodings for the codec sequencer: state codes, cfg bit positions, counter width.
package codec_seq_pkg;

  localparam int CNT_W = 20;
  localparam int CFG_W = 7;

  localparam int CFG_CSEL = 6;
  localparam int CFG_FS1  = 5;
  localparam int CFG_FS2  = 4;
  localparam int CFG_SR   = 3;
  localparam int CFG_FMT  = 2;
  localparam int CFG_MD1  = 1;
  localparam int CFG_MD2  = 0;

  typedef enum logic [2:0] {
    ST_APPLY  = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOCK   = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4,
    ST_MUTE   = 3'd5
  } state_e;

  // Zero-length phases behave as one cycle; oversize values pin to the counter ceiling.
  function automatic logic [CNT_W-1:0] clamp_cnt(input int unsigned v);
    if (v == 0) return CNT_W'(1);
    if ((v >> CNT_W) != 0) return '1;
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/lrck_mon.sv
// LRCK activity monitor: 2-flop synchronizer, rising-edge detect, edge counter, gap watchdog.
// An LRCK rising transition is counted on the 3rd clk edge after it; counters saturate.
module lrck_mon
  import codec_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] WDOG = 20'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_lrck,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_edge_cnt,
  output logic             o_gap_expired
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_gap;
  logic             w_edge;

  assign w_edge = r_sync2 & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_prev     <= 1'b0;
      r_edge_cnt <= '0;
      r_gap      <= '0;
    end else begin
      r_sync1 <= i_lrck;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (i_clear) begin
        r_edge_cnt <= '0;
        r_gap      <= '0;
      end else if (i_enable) begin
        if (w_edge) begin
          r_gap <= '0;
          if (r_edge_cnt != {CNT_W{1'b1}}) r_edge_cnt <= r_edge_cnt + 1'b1;
        end else if (r_gap != {CNT_W{1'b1}}) begin
          r_gap <= r_gap + 1'b1;
        end
      end
    end
  end

  assign o_edge_cnt    = r_edge_cnt;
  assign o_gap_expired = (r_gap >= WDOG);

endmodule

// File: rtl/codec_seq_ctrl.sv
// Codec power-up/reconfig sequencer: mute -> apply pins -> settle -> LRCK lock -> run.
// Outputs are registered from next-state so they line up with the state register.
module codec_seq_ctrl
  import codec_seq_pkg::*;
#(
  parameter int unsigned      MUTE_CYCLES   = 4096,
  parameter int unsigned      SETTLE_CYCLES = 50000,
  parameter int unsigned      LRCK_EDGES    = 16,
  parameter int unsigned      LOCK_TIMEOUT  = 500000,
  parameter int unsigned      WDOG_CYCLES   = 100000,
  parameter logic [CFG_W-1:0] DEF_CFG       = 7'b0000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [6:0] cfg_data,
  input  logic       i_adc_lrck,
  output logic       o_pll_csel,
  output logic       o_pll_fs1,
  output logic       o_pll_fs2,
  output logic       o_pll_sr,
  output logic       o_adc_fmt,
  output logic       o_adc_md1,
  output logic       o_adc_md2,
  output logic       o_dac_nmute,
  output logic       audio_ok,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] LP_MUTE    = clamp_cnt(MUTE_CYCLES);
  localparam logic [CNT_W-1:0] LP_SETTLE  = clamp_cnt(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] LP_EDGES   = clamp_cnt(LRCK_EDGES);
  localparam logic [CNT_W-1:0] LP_LOCK_TO = clamp_cnt(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] LP_WDOG    = clamp_cnt(WDOG_CYCLES);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_edge_cnt;
  logic             w_cnt_clr;
  logic             w_gap_expired;
  logic             w_accept;
  logic             w_mon_clr;
  logic             w_mon_en;
  logic [6:0]       r_cfg;
  logic [6:0]       r_pins;
  logic             r_nmute;
  logic             r_audio_ok;
  logic             r_fault;
  logic             r_cfg_ready;

  assign w_accept  = cfg_valid & r_cfg_ready;
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
  assign w_mon_clr = (r_state == ST_SETTLE);
  assign w_mon_en  = (r_state == ST_LOCK) || (r_state == ST_RUN);

  lrck_mon #(
    .WDOG(LP_WDOG)
  ) u_lrck_mon (
    .clk          (clk),
    .rst          (rst),
    .i_lrck       (i_adc_lrck),
    .i_clear      (w_mon_clr),
    .i_enable     (w_mon_en),
    .o_edge_cnt   (w_edge_cnt),
    .o_gap_expired(w_gap_expired)
  );

  // Priority: lock beats lock-timeout, host accept beats watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_APPLY: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_clr   = 1'b1;
      end
      ST_SETTLE: if (w_cnt_inc >= LP_SETTLE) begin
        w_state_nxt = ST_LOCK;
        w_cnt_clr   = 1'b1;
      end
      ST_LOCK: begin
        if (w_edge_cnt >= LP_EDGES) begin
          w_state_nxt = ST_RUN;
          w_cnt_clr   = 1'b1;
        end else if (w_cnt_inc >= LP_LOCK_TO) begin
          w_state_nxt = ST_FAULT;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_state_nxt = ST_MUTE;
          w_cnt_clr   = 1'b1;
        end else if (w_gap_expired) begin
          w_state_nxt = ST_FAULT;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_FAULT: if (w_accept) begin
        w_state_nxt = ST_MUTE;
        w_cnt_clr   = 1'b1;
      end
      ST_MUTE: if (w_cnt_inc >= LP_MUTE) begin
        w_state_nxt = ST_APPLY;
        w_cnt_clr   = 1'b1;
      end
      default: begin
        w_state_nxt = ST_APPLY;
        w_cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_APPLY;
      r_cnt       <= '0;
      r_cfg       <= DEF_CFG;
      r_pins      <= DEF_CFG;
      r_nmute     <= 1'b0;
      r_audio_ok  <= 1'b0;
      r_fault     <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_clr ? '0 : w_cnt_inc;
      if (w_accept) r_cfg <= cfg_data;
      // Pins only move on the APPLY cycle, which is always reached with the DAC muted.
      if (r_state == ST_APPLY) r_pins <= r_cfg;
      r_nmute     <= (w_state_nxt == ST_RUN);
      r_audio_ok  <= (w_state_nxt == ST_RUN);
      r_fault     <= (w_state_nxt == ST_FAULT);
      r_cfg_ready <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FAULT);
    end
  end

  assign state       = r_state;
  assign cfg_ready   = r_cfg_ready;
  assign o_dac_nmute = r_nmute;
  assign audio_ok    = r_audio_ok;
  assign fault       = r_fault;
  assign o_pll_csel  = r_pins[CFG_CSEL];
  assign o_pll_fs1   = r_pins[CFG_FS1];
  assign o_pll_fs2   = r_pins[CFG_FS2];
  assign o_pll_sr    = r_pins[CFG_SR];
  assign o_adc_fmt   = r_pins[CFG_FMT];
  assign o_adc_md1   = r_pins[CFG_MD1];
  assign o_adc_md2   = r_pins[CFG_MD2];

endmodule

// File: tb/tb_codec_seq_ctrl.sv
// Bench for codec_seq_ctrl: directed sequences plus random traffic against a timestamp-based model.
module tb_codec_seq_ctrl;

  localparam int M  = 4;
  localparam int S  = 8;
  localparam int E  = 3;
  localparam int LT = 40;
  localparam int W  = 20;
  localparam logic [6:0] DEF = 7'b1000110;

  localparam int ST_A = 0;
  localparam int ST_S = 1;
  localparam int ST_L = 2;
  localparam int ST_R = 3;
  localparam int ST_F = 4;
  localparam int ST_M = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [6:0] cfg_data;
  logic       i_adc_lrck;
  logic       o_pll_csel, o_pll_fs1, o_pll_fs2, o_pll_sr;
  logic       o_adc_fmt, o_adc_md1, o_adc_md2;
  logic       o_dac_nmute, audio_ok, fault;
  logic [2:0] state;
  logic [6:0] pins_obs;

  assign pins_obs = {o_pll_csel, o_pll_fs1, o_pll_fs2, o_pll_sr, o_adc_fmt, o_adc_md1, o_adc_md2};

  codec_seq_ctrl #(
    .MUTE_CYCLES  (M),
    .SETTLE_CYCLES(S),
    .LRCK_EDGES   (E),
    .LOCK_TIMEOUT (LT),
    .WDOG_CYCLES  (W),
    .DEF_CFG      (DEF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .i_adc_lrck (i_adc_lrck),
    .o_pll_csel (o_pll_csel),
    .o_pll_fs1  (o_pll_fs1),
    .o_pll_fs2  (o_pll_fs2),
    .o_pll_sr   (o_pll_sr),
    .o_adc_fmt  (o_adc_fmt),
    .o_adc_md1  (o_adc_md1),
    .o_adc_md2  (o_adc_md2),
    .o_dac_nmute(o_dac_nmute),
    .audio_ok   (audio_ok),
    .fault      (fault),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Stimulus controls
  logic       rst_r     = 1'b0;
  logic       host_vld  = 1'b0;
  logic [6:0] host_dat  = 7'd0;
  logic       lrck_r    = 1'b0;
  logic       lrck_on   = 1'b0;
  int         lrck_half = 6;
  int         lrck_ph   = 0;

  // Model: phase plus the clock edge it was entered on; LRCK history of pin samples.
  int         m_st = ST_A;
  int         m_te = 0;
  int         m_ec = 0;
  int         m_lc = 0;
  logic [6:0] m_cfg  = DEF;
  logic [6:0] m_pins = DEF;
  logic       smp[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model across clock edge number cyc using the inputs presented for it.
  task automatic model_edge(output bit acc);
    int n;
    int pre;
    int nxt;
    bit gap_exp;
    acc = 1'b0;
    smp[3] = smp[2];
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = lrck_r;
    if (rst_r) begin
      m_st = ST_A; m_te = cyc; m_cfg = DEF; m_pins = DEF; m_ec = 0; m_lc = cyc;
      return;
    end
    n       = cyc - m_te;
    pre     = m_st;
    nxt     = pre;
    gap_exp = ((cyc - 1 - m_lc) >= W);
    case (pre)
      ST_A: begin m_pins = m_cfg; nxt = ST_S; end
      ST_S: if (n >= S) nxt = ST_L;
      ST_L: begin
        if (m_ec >= E) nxt = ST_R;
        else if (n >= LT) nxt = ST_F;
      end
      ST_R: begin
        if (host_vld) begin acc = 1'b1; nxt = ST_M; end
        else if (gap_exp) nxt = ST_F;
      end
      ST_F: if (host_vld) begin acc = 1'b1; nxt = ST_M; end
      ST_M: if (n >= M) nxt = ST_A;
      default: nxt = ST_A;
    endcase
    if (acc) m_cfg = host_dat;
    if (pre == ST_S) begin
      m_ec = 0; m_lc = cyc;
    end else if ((pre == ST_L || pre == ST_R) && smp[2] && !smp[3]) begin
      m_ec++; m_lc = cyc;
    end
    if (nxt != pre) begin m_st = nxt; m_te = cyc; end
  endtask

  task automatic step(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (lrck_on) begin
        lrck_ph++;
        if (lrck_ph >= lrck_half) begin lrck_r = ~lrck_r; lrck_ph = 0; end
      end
      rst        = rst_r;
      cfg_valid  = host_vld;
      cfg_data   = host_dat;
      i_adc_lrck = lrck_r;
      @(posedge clk);
      cyc++;
      model_edge(acc);
      #1;
      check_eq("status", {25'd0, o_dac_nmute, audio_ok, fault, cfg_ready, state},
               {25'd0, m_st == ST_R, m_st == ST_R, m_st == ST_F,
                (m_st == ST_R) || (m_st == ST_F), 3'(m_st)});
      check_eq("pins", {25'd0, pins_obs}, {25'd0, m_pins});
      if (acc) host_vld = 1'b0;
    end
  endtask

  initial begin
    int r;
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = 7'd0; i_adc_lrck = 1'b0;
    for (int k = 0; k < 4; k++) smp[k] = 1'b0;

    // Power-up with LRCK toggling every 6 clk
    lrck_on = 1'b1; lrck_half = 6; rst_r = 1'b1;
    step(2);
    rst_r = 1'b0;
    check_eq("rst_state", 32'(state), 32'(ST_A));
    check_eq("rst_pins", 32'(pins_obs), 32'(DEF));
    check_eq("rst_nmute", 32'(o_dac_nmute), 0);
    check_eq("rst_ready", 32'(cfg_ready), 0);
    step(60);
    check_eq("run_state", 32'(state), 32'(ST_R));
    check_eq("run_ok", 32'(audio_ok), 1);
    check_eq("run_pins", 32'(pins_obs), 32'(DEF));

    // Reconfigure from RUN with a one-cycle request
    host_dat = 7'b0110101; host_vld = 1'b1;
    step(1);
    check_eq("acc_nmute", 32'(o_dac_nmute), 0);
    check_eq("acc_ready", 32'(cfg_ready), 0);
    step(4);
    check_eq("pins_t5", 32'(pins_obs), 32'(DEF));
    step(1);
    check_eq("pins_t6", 32'(pins_obs), 32'h35);
    step(60);
    check_eq("relock", 32'(state), 32'(ST_R));

    // LRCK dead from reset: lock timeout, then recovery through a request
    lrck_on = 1'b0; lrck_r = 1'b0; rst_r = 1'b1;
    step(1);
    rst_r = 1'b0;
    step(55);
    check_eq("lt_fault", 32'(fault), 1);
    check_eq("lt_nmute", 32'(o_dac_nmute), 0);
    lrck_on = 1'b1; host_dat = 7'($urandom_range(0, 127)); host_vld = 1'b1;
    step(1);
    check_eq("lt_restart", 32'(state), 32'(ST_M));
    step(70);
    check_eq("lt_recover", 32'(state), 32'(ST_R));

    // Watchdog: LRCK stops in RUN; fault latches even after LRCK returns
    lrck_on = 1'b0;
    step(40);
    check_eq("wd_fault", 32'(fault), 1);
    lrck_on = 1'b1;
    step(40);
    check_eq("wd_sticky", 32'(state), 32'(ST_F));
    host_dat = 7'($urandom_range(0, 127)); host_vld = 1'b1;
    step(80);
    check_eq("wd_recover", 32'(state), 32'(ST_R));

    // Request raised during SETTLE and held until the first RUN cycle
    rst_r = 1'b1;
    step(1);
    rst_r = 1'b0;
    step(3);
    host_dat = 7'b1111000; host_vld = 1'b1;
    step(10);
    check_eq("pend_ready", 32'(cfg_ready), 0);
    for (int i = 0; i < 80 && host_vld; i++) step(1);
    check_eq("pend_accepted", 32'(host_vld), 0);
    check_eq("pend_state", 32'(state), 32'(ST_M));
    step(70);
    check_eq("pend_pins", 32'(pins_obs), 32'h78);

    // Reset mid-MUTE drops the latched cfg; reset during LOCK restarts cleanly
    host_dat = 7'b0000001; host_vld = 1'b1;
    step(3);
    rst_r = 1'b1;
    step(1);
    rst_r = 1'b0;
    check_eq("rstm_pins", 32'(pins_obs), 32'(DEF));
    step(11);
    check_eq("pre_rst_lock", 32'(state), 32'(ST_L));
    rst_r = 1'b1;
    step(1);
    rst_r = 1'b0;
    check_eq("rstl_state", 32'(state), 32'(ST_A));
    check_eq("rstl_nmute", 32'(o_dac_nmute), 0);
    step(70);
    check_eq("rstl_pins", 32'(pins_obs), 32'(DEF));

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) lrck_half = int'($urandom_range(2, 9));
      else if (r < 4) lrck_on = ~lrck_on;
      else if (r < 8 && !host_vld) begin
        host_vld = 1'b1;
        host_dat = 7'($urandom_range(0, 127));
      end
      rst_r = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst_r = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
